// File: rtl/sd_pkg.sv
// Shared encodings for the SD CMD-line engine: response types, FSM states,
// status bit positions and the CRC7 generator polynomial.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'd0,
        RESP_R48       = 2'd1,
        RESP_R48_NOCRC = 2'd2,
        RESP_RSVD      = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        GAP,
        DONE
    } state_e;

    localparam int unsigned ST_TIMEOUT = 0;
    localparam int unsigned ST_CRC     = 1;
    localparam int unsigned ST_IDX     = 2;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1) with synchronous clear; one bit folded in per enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    assign fb    = bit_i ^ crc_q[6];
    assign crc_o = crc_q;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line sequencer: sd_clk generation, 48-bit command TX with CRC7 and
// 48-bit response capture. Define SD_CMD_CRC_CHECK_EN to enable response CRC/framing checks.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 32,
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned NCC_CLKS     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  resp_type,
    output logic        resp_valid,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic [2:0]  resp_status,
    output logic        busy,
    output logic        sd_clk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i
);

    logic [7:0]  div_q, div_d;
    logic        sdclk_q, sdclk_d;
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] wait_q, wait_d;
    logic [39:0] tx_q, tx_d;
    logic [46:0] rx_q, rx_d;
    logic [5:0]  idx_q, idx_d;
    resp_type_e  rtype_q, rtype_d;
    logic [2:0]  stat_q, stat_d;
    logic        upd_q, upd_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic [5:0]  rindex_q, rindex_d;
    logic [31:0] rarg_q, rarg_d;
    logic [2:0]  rstat_q, rstat_d;

    logic        terminal, rise_tick, fall_tick;
    logic        accept, tx_en;
    logic [6:0]  tx_crc;
    logic [2:0]  crc_sel;
    logic        idx_err, crc_err;

    assign terminal  = (div_q == 8'(CLK_DIV - 1));
    assign rise_tick = terminal & ~sdclk_q;
    assign fall_tick = terminal & sdclk_q;
    assign accept    = (state_q == IDLE) & cmd_valid;
    // cnt_q counts bits still to drive; 48..9 are payload, 8..2 CRC, 1 end bit
    assign tx_en     = (state_q == SEND) & fall_tick & (cnt_q > 6'd8);
    assign crc_sel   = 3'(cnt_q - 6'd2);

    sd_crc7 u_tx_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (tx_en),
        .bit_i (tx_q[39]),
        .crc_o (tx_crc)
    );

`ifdef SD_CMD_CRC_CHECK_EN
    logic       rx_en;
    logic [6:0] rx_crc;

    // Start bit is 0 and leaves a cleared CRC at 0, so only bits 46..8 are fed
    assign rx_en = (state_q == RECV) & rise_tick & (cnt_q > 6'd8);

    sd_crc7 u_rx_crc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == WAIT),
        .en_i  (rx_en),
        .bit_i (sd_cmd_i),
        .crc_o (rx_crc)
    );

    assign crc_err = rx_q[46] | ~rx_q[0] |
                     ((rtype_q == RESP_R48) & (rx_q[7:1] != rx_crc));
`else
    logic unused_rx;
    assign unused_rx = ^{rx_q[46], rx_q[7:0]};
    assign crc_err   = 1'b0;
`endif

    assign idx_err = (rtype_q == RESP_R48) & (rx_q[45:40] != idx_q);

    always_comb begin
        div_d    = terminal ? 8'd0 : div_q + 8'd1;
        sdclk_d  = sdclk_q ^ terminal;
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        idx_d    = idx_q;
        rtype_d  = rtype_q;
        stat_d   = stat_q;
        upd_d    = upd_q;
        out_d    = out_q;
        oe_d     = oe_q;
        rindex_d = rindex_q;
        rarg_d   = rarg_q;
        rstat_d  = rstat_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_d    = {2'b01, cmd_index, cmd_arg};
                    idx_d   = cmd_index;
                    rtype_d = (resp_type == RESP_RSVD) ? RESP_NONE : resp_type_e'(resp_type);
                    cnt_d   = 6'd48;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fall_tick) begin
                    if (cnt_q == 6'd0) begin
                        out_d   = 1'b1;
                        oe_d    = 1'b0;
                        wait_d  = '0;
                        stat_d  = '0;
                        upd_d   = 1'b0;
                        state_d = (rtype_q == RESP_NONE) ? GAP : WAIT;
                    end else begin
                        oe_d  = 1'b1;
                        cnt_d = cnt_q - 6'd1;
                        if (cnt_q > 6'd8) begin
                            out_d = tx_q[39];
                            tx_d  = {tx_q[38:0], 1'b0};
                        end else if (cnt_q > 6'd1) begin
                            out_d = tx_crc[crc_sel];
                        end else begin
                            out_d = 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (rise_tick) begin
                    if (!sd_cmd_i) begin
                        cnt_d   = 6'd47;
                        state_d = RECV;
                    end else if (wait_q == 16'(RESP_TIMEOUT - 1)) begin
                        stat_d[ST_TIMEOUT] = 1'b1;
                        wait_d  = '0;
                        state_d = GAP;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            RECV: begin
                if (cnt_q == 6'd0) begin
                    stat_d[ST_IDX] = idx_err;
                    stat_d[ST_CRC] = crc_err;
                    upd_d   = 1'b1;
                    wait_d  = '0;
                    state_d = GAP;
                end else if (rise_tick) begin
                    rx_d  = {rx_q[45:0], sd_cmd_i};
                    cnt_d = cnt_q - 6'd1;
                end
            end
            GAP: begin
                if (rise_tick) begin
                    if (wait_q == 16'(NCC_CLKS - 1)) begin
                        rstat_d = stat_q;
                        if (upd_q) begin
                            rindex_d = rx_q[45:40];
                            rarg_d   = rx_q[39:8];
                        end
                        state_d = DONE;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            sdclk_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            idx_q    <= '0;
            rtype_q  <= RESP_NONE;
            stat_q   <= '0;
            upd_q    <= 1'b0;
            out_q    <= 1'b1;
            oe_q     <= 1'b0;
            rindex_q <= '0;
            rarg_q   <= '0;
            rstat_q  <= '0;
        end else begin
            div_q    <= div_d;
            sdclk_q  <= sdclk_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            idx_q    <= idx_d;
            rtype_q  <= rtype_d;
            stat_q   <= stat_d;
            upd_q    <= upd_d;
            out_q    <= out_d;
            oe_q     <= oe_d;
            rindex_q <= rindex_d;
            rarg_q   <= rarg_d;
            rstat_q  <= rstat_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = ~cmd_ready;
    assign resp_valid  = (state_q == DONE);
    assign resp_index  = rindex_q;
    assign resp_arg    = rarg_q;
    assign resp_status = rstat_q;
    assign sd_clk      = sdclk_q;
    assign sd_cmd_o    = out_q;
    assign sd_cmd_oe   = oe_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: expected frames/responses are queued by
// the stimulus thread and checked by independent frame and response monitors.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  resp_type;
    logic        resp_valid;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic [2:0]  resp_status;
    logic        busy;
    logic        sd_clk;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        sd_cmd_i;

    int checks = 0;
    int errors = 0;
    int n_expected = 0;
    int n_seen = 0;
    int fcnt = 0;
    logic [47:0] fsh;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [2:0]  st;
    } resp_t;

    resp_t       resp_q[$];
    logic [47:0] frame_q[$];

    sd_cmd_engine #(.CLK_DIV(3), .RESP_TIMEOUT(64), .NCC_CLKS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .resp_type   (resp_type),
        .resp_valid  (resp_valid),
        .resp_index  (resp_index),
        .resp_arg    (resp_arg),
        .resp_status (resp_status),
        .busy        (busy),
        .sd_clk      (sd_clk),
        .sd_cmd_o    (sd_cmd_o),
        .sd_cmd_oe   (sd_cmd_oe),
        .sd_cmd_i    (sd_cmd_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_fn(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Frame monitor: collect bits on rising sd_clk while the engine drives CMD
    always @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            fcnt = 0;
        end else if (sd_cmd_oe) begin
            fsh  = {fsh[46:0], sd_cmd_o};
            fcnt = fcnt + 1;
            if (fcnt == 48) begin
                fcnt = 0;
                if (frame_q.size() == 0) begin
                    chk("unexpected_frame", {16'h0, fsh}, 64'h0);
                end else begin
                    chk("frame", {16'h0, fsh}, {16'h0, frame_q.pop_front()});
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            n_seen++;
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'h0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_index",  64'(resp_index),  64'(e.idx));
                chk("resp_arg",    64'(resp_arg),    64'(e.arg));
                chk("resp_status", 64'(resp_status), 64'(e.st));
            end
        end
    end

    task automatic push_resp(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] st);
        resp_t e;
        e.idx = idx;
        e.arg = arg;
        e.st  = st;
        resp_q.push_back(e);
        n_expected++;
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
        int n;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("ready_wait_timeout", 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_index = $urandom_range(0, 63);
        cmd_arg   = $urandom;
        resp_type = 2'($urandom_range(0, 3));
        chk("ready_drop", 64'(cmd_ready), 64'h0);
        chk("busy_set", 64'(busy), 64'h1);
    endtask

    task automatic card_reply(input logic [47:0] f, input int dly);
        int n;
        n = 0;
        while (!sd_cmd_oe && n < 5000) begin @(negedge clk); n++; end
        while (sd_cmd_oe && n < 10000) begin @(negedge clk); n++; end
        if (n >= 10000) begin
            chk("tx_end_timeout", 64'(sd_cmd_oe), 64'h0);
        end else begin
            repeat (dly) @(negedge sd_clk);
            for (int i = 47; i >= 0; i--) begin
                sd_cmd_i = f[i];
                @(negedge sd_clk);
            end
        end
        sd_cmd_i = 1'b1;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (n_seen != n_expected && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n_seen != n_expected) chk("resp_wait_timeout", 64'(n_seen), 64'(n_expected));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=stalled required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] a41;
        logic [2:0]  crc_bad_st;
        int          n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        resp_type = '0;
        sd_cmd_i  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  64'(cmd_ready),   64'h1);
        chk("rst_busy",   64'(busy),        64'h0);
        chk("rst_oe",     64'(sd_cmd_oe),   64'h0);
        chk("rst_cmd_o",  64'(sd_cmd_o),    64'h1);
        chk("rst_rvalid", 64'(resp_valid),  64'h0);
        chk("rst_rindex", 64'(resp_index),  64'h0);
        chk("rst_rarg",   64'(resp_arg),    64'h0);
        chk("rst_rstat",  64'(resp_status), 64'h0);

        // CMD0, no response
        frame_q.push_back(48'h400000000095);
        push_resp(6'd0, 32'h0, 3'b000);
        send_cmd(6'd0, 32'h0, 2'd0);
        wait_resp();

        // CMD8 with good R7 reply
        frame_q.push_back(48'h48000001AA87);
        push_resp(6'd8, 32'h000001AA, 3'b000);
        send_cmd(6'd8, 32'h000001AA, 2'd1);
        card_reply(48'h48000001AA87, 5);
        wait_resp();

        // CMD8 with corrupted CRC byte (end bit now 0)
`ifdef SD_CMD_CRC_CHECK_EN
        crc_bad_st = 3'b010;
`else
        crc_bad_st = 3'b000;
`endif
        frame_q.push_back(48'h48000001AA87);
        push_resp(6'd8, 32'h000001AA, crc_bad_st);
        send_cmd(6'd8, 32'h000001AA, 2'd1);
        card_reply(48'h48000001AA86, 5);
        wait_resp();

        // CMD55, card silent -> timeout, previous response data held
        frame_q.push_back(48'h770000000065);
        push_resp(6'd8, 32'h000001AA, 3'b001);
        send_cmd(6'd55, 32'h0, 2'd1);
        wait_resp();

        // ACMD41, R3 without CRC/index checking
        a41 = {2'b01, 6'd41, 32'h40FF8000};
        frame_q.push_back({a41, crc7_fn(a41), 1'b1});
        push_resp(6'h3F, 32'h80FF8000, 3'b000);
        send_cmd(6'd41, 32'h40FF8000, 2'd2);
        card_reply(48'h3F80FF8000FF, 5);
        wait_resp();

        // Reserved response type behaves as none
        frame_q.push_back(48'h400000000095);
        push_resp(6'h3F, 32'h80FF8000, 3'b000);
        send_cmd(6'd0, 32'h0, 2'd3);
        wait_resp();

        // Reset mid-SEND: abort without a response
        send_cmd(6'd8, 32'h000001AA, 2'd1);
        n = 0;
        while (fcnt != 27 && n < 5000) begin @(negedge clk); n++; end
        chk("abort_point", 64'(fcnt), 64'd27);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_oe",    64'(sd_cmd_oe),  64'h0);
        chk("abort_cmd_o", 64'(sd_cmd_o),   64'h1);
        chk("abort_ready", 64'(cmd_ready),  64'h1);
        chk("abort_rarg",  64'(resp_arg),   64'h0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_resp", 64'(n_seen), 64'(n_expected));

        // Normal CMD0 after the abort
        frame_q.push_back(48'h400000000095);
        push_resp(6'd0, 32'h0, 3'b000);
        send_cmd(6'd0, 32'h0, 2'd0);
        wait_resp();

        repeat (50) @(negedge clk);
        chk("frames_left", 64'(frame_q.size()), 64'h0);
        chk("resps_left",  64'(resp_q.size()),  64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
